demux_16_4outputs_buf: RTL and testbench

DEMUX_16_4OUTPUTS_BUF -- requirements
Module: demux_16_4outputs_buf

---
 rtl/demux_16_4outputs_buf_pkg.sv | 15 +
 rtl/demux_lane_reg.sv | 21 ++
 rtl/demux_16_4outputs_buf.sv | 118 +++++++++++
 tb/tb_demux_16_4outputs_buf.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_16_4outputs_buf_pkg.sv
// Shared constants and types for the 4-lane word demultiplexer with bundle buffer.
package demux_16_4outputs_buf_pkg;

  localparam int DEMUX_WIDTH = 16;
  localparam int DEMUX_LANES = 4;

  // FILL collects words into lanes; FULL presents the completed bundle.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/demux_lane_reg.sv
// One lane of bundle storage: WIDTH-bit register with write enable, cleared by reset.
module demux_lane_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture the word when this lane is selected; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demux_16_4outputs_buf.sv
// Distributes incoming words across four registered lanes, either round-robin
// or by explicit lane select, and presents them as one bundle once every lane
// has been written. The bundle is held until the consumer acknowledges it.
module demux_16_4outputs_buf
  import demux_16_4outputs_buf_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int LANES = DEMUX_LANES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel_mode,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [3:0]       filled
);

  state_t             state;
  lane_t              ptr;
  logic [LANES-1:0]   filled_r;
  logic [LANES-1:0]   we;
  logic [LANES-1:0]   filled_nxt;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               accept;
  lane_t              lane;
  logic [WIDTH-1:0]   lane_q [LANES];

  // in_ready is a registered flag, additionally masked while reset is held
  // so the block never advertises readiness during reset.
  assign in_ready  = in_ready_r & ~reset;
  assign out_valid = out_valid_r;
  assign filled    = filled_r;

  assign accept = in_valid & in_ready;
  assign lane   = sel_mode ? sel : ptr;

  // Select which lane, if any, captures the incoming word this cycle.
  always_comb begin
    we = '0;
    if (accept) begin
      for (int n = 0; n < LANES; n++) begin
        we[n] = (lane == lane_t'(n));
      end
    end
  end

  // Rewriting an already-filled lane leaves the set of filled bits unchanged.
  assign filled_nxt = filled_r | we;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    demux_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .we   (we[n]),
      .d    (in_data),
      .q    (lane_q[n])
    );
  end

  assign out0 = lane_q[0];
  assign out1 = lane_q[1];
  assign out2 = lane_q[2];
  assign out3 = lane_q[3];

  // Bundle state machine: fill lanes, go FULL on the completing write, and
  // return to FILL on acknowledge with lane data retained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      ptr         <= '0;
      filled_r    <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            filled_r <= filled_nxt;
            if (!sel_mode) begin
              ptr <= ptr + lane_t'(1);
            end
            if (&filled_nxt) begin
              state       <= FULL;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ack) begin
            state       <= FILL;
            ptr         <= '0;
            filled_r    <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_16_4outputs_buf.sv
// Bench for demux_16_4outputs_buf: directed stimulus with a bundle scoreboard.
module tb_demux_16_4outputs_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        sel_mode;
  logic [1:0]  sel;
  logic [15:0] out0, out1, out2, out3;
  logic        out_valid;
  logic        out_ack;
  logic [3:0]  filled;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] cur_exp;
  logic        have_exp = 1'b0;
  logic        prev_valid = 1'b0;

  demux_16_4outputs_buf dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel_mode (sel_mode),
    .sel      (sel),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .filled   (filled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Offer one word for exactly one clock edge.
  task automatic word(input logic [15:0] d, input logic m, input logic [1:0] s);
    in_valid = 1'b1;
    in_data  = d;
    sel_mode = m;
    sel      = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
  endtask

  // Monitor: on each rising out_valid pop the expected bundle, then require
  // the lanes to stay equal to it for every cycle out_valid remains high.
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bundle: got %h%h%h%h want none", out3, out2, out1, out0);
        have_exp <= 1'b0;
      end else begin
        cur_exp = exp_q.pop_front();
        have_exp <= 1'b1;
        chk("bundle_out0", 32'(out0), 32'(cur_exp[15:0]));
        chk("bundle_out1", 32'(out1), 32'(cur_exp[31:16]));
        chk("bundle_out2", 32'(out2), 32'(cur_exp[47:32]));
        chk("bundle_out3", 32'(out3), 32'(cur_exp[63:48]));
      end
    end else if (out_valid && have_exp) begin
      total++;
      if ({out3, out2, out1, out0} !== cur_exp) begin
        bad++;
        $display("FAIL bundle_stable: got %h%h%h%h want %h", out3, out2, out1, out0, cur_exp);
      end
    end
    prev_valid <= out_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    sel_mode = 1'b0;
    sel      = '0;
    out_ack  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_filled",    32'(filled),    32'h0);
    chk("rst_out0",      32'(out0),      32'h0);
    chk("rst_out3",      32'(out3),      32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Round-robin fill.
    exp_q.push_back({16'h0044, 16'h0033, 16'h0022, 16'h0011});
    word(16'h0011, 1'b0, 2'd0);
    word(16'h0022, 1'b0, 2'd0);
    word(16'h0033, 1'b0, 2'd0);
    chk("rr_not_yet_valid", 32'(out_valid), 32'h0);
    chk("rr_filled3",       32'(filled),    32'h7);
    word(16'h0044, 1'b0, 2'd0);
    chk("rr_out_valid", 32'(out_valid), 32'h1);
    chk("rr_in_ready",  32'(in_ready),  32'h0);
    chk("rr_filled",    32'(filled),    32'hF);
    @(posedge clk);
    #1;
    ack();
    chk("ack_out_valid", 32'(out_valid), 32'h0);
    chk("ack_filled",    32'(filled),    32'h0);
    chk("ack_in_ready",  32'(in_ready),  32'h1);
    chk("ack_retain0",   32'(out0),      32'h0011);

    // Explicit lane with overwrite.
    word(16'hAAAA, 1'b1, 2'd2);
    word(16'hBBBB, 1'b1, 2'd2);
    chk("ow_out2",   32'(out2),   32'hBBBB);
    chk("ow_filled", 32'(filled), 32'h4);
    exp_q.push_back({16'h0303, 16'hBBBB, 16'h0101, 16'h0100});
    word(16'h0100, 1'b1, 2'd0);
    word(16'h0101, 1'b1, 2'd1);
    word(16'h0303, 1'b1, 2'd3);
    chk("ow_out_valid", 32'(out_valid), 32'h1);
    chk("ow_out2_kept", 32'(out2),      32'hBBBB);

    // Backpressure while FULL, then ack together with a pending word.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    sel_mode = 1'b0;
    sel      = 2'd0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out0",     32'(out0),     32'h0100);
    end
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    chk("bp_ack_filled", 32'(filled), 32'h0);
    chk("bp_ack_out0",   32'(out0),   32'h0100);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_take_out0",   32'(out0),   32'h1234);
    chk("bp_take_filled", 32'(filled), 32'h1);

    // Reset mid-bundle, applied between edges.
    word(16'h5555, 1'b0, 2'd0);
    chk("mid_filled", 32'(filled), 32'h3);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_filled",   32'(filled),    32'h0);
    chk("arst_out0",     32'(out0),      32'h0);
    chk("arst_out1",     32'(out1),      32'h0);
    chk("arst_out_val",  32'(out_valid), 32'h0);
    chk("arst_in_ready", 32'(in_ready),  32'h0);
    reset = 1'b0;
    #1;
    word(16'h7777, 1'b0, 2'd0);
    chk("arst_next_out0", 32'(out0),   32'h7777);
    chk("arst_next_fill", 32'(filled), 32'h1);

    // Mixed mode, with out_ack asserted during FILL (must be ignored).
    #3;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    out_ack = 1'b1;
    word(16'h0F0F, 1'b1, 2'd3);
    out_ack = 1'b0;
    chk("mix_filled", 32'(filled), 32'h8);
    exp_q.push_back({16'h0F0F, 16'h0003, 16'h0002, 16'h0001});
    word(16'h0001, 1'b0, 2'd0);
    word(16'h0002, 1'b0, 2'd0);
    word(16'h0003, 1'b0, 2'd0);
    chk("mix_out_valid", 32'(out_valid), 32'h1);
    @(posedge clk);
    #1;
    ack();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
